// File: rtl/slow_clk_receiver.sv
// slow_clk_receiver: brings the divided slow clock into the clk domain,
// turns each rising edge into a one-cycle tick, counts ticks as MM:SS BCD
// and watches for a missing or stalled slow clock.
module slow_clk_receiver #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 134217728,
   parameter int CNT_W          = 28
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       slow_in,
   input  logic       en,
   input  logic       clear,
   output logic       tick,
   output logic [3:0] sec_ones,
   output logic [2:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [2:0] min_tens,
   output logic       wrap,
   output logic       locked,
   output logic       stalled
);

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      RUNNING    = 2'd1,
      STALLED    = 2'd2
   } state_e;

   // Saturation value of the watchdog; reaching it with no tick is a timeout.
   localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic                   tick_q, tick_d;
   logic [3:0]             sec_ones_q, sec_ones_d;
   logic [2:0]             sec_tens_q, sec_tens_d;
   logic [3:0]             min_ones_q, min_ones_d;
   logic [2:0]             min_tens_q, min_tens_d;
   logic                   wrap_q, wrap_d;
   logic [CNT_W-1:0]       wd_q, wd_d;
   state_e                 state_q, state_d;
   logic                   locked_q, locked_d;
   logic                   stalled_q, stalled_d;
   logic                   timeout;

   // Synchronizer shift chain and rising-edge detect against the history flop.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], slow_in};
      hist_d = sync_q[SYNC_STAGES-1];
      tick_d = sync_q[SYNC_STAGES-1] & ~hist_q;
   end

   // BCD MM:SS counter; clear wins over tick, wrap pulses on the 59:59 rollover.
   // Comparisons use >= so a corrupted field recovers to a legal BCD value.
   always_comb begin
      sec_ones_d = sec_ones_q;
      sec_tens_d = sec_tens_q;
      min_ones_d = min_ones_q;
      min_tens_d = min_tens_q;
      wrap_d     = 1'b0;
      if (clear) begin
         sec_ones_d = 4'd0;
         sec_tens_d = 3'd0;
         min_ones_d = 4'd0;
         min_tens_d = 3'd0;
      end else if (tick_q && en) begin
         if (sec_ones_q >= 4'd9) begin
            sec_ones_d = 4'd0;
            if (sec_tens_q >= 3'd5) begin
               sec_tens_d = 3'd0;
               if (min_ones_q >= 4'd9) begin
                  min_ones_d = 4'd0;
                  if (min_tens_q >= 3'd5) begin
                     min_tens_d = 3'd0;
                     wrap_d     = 1'b1;
                  end else begin
                     min_tens_d = min_tens_q + 3'd1;
                  end
               end else begin
                  min_ones_d = min_ones_q + 4'd1;
               end
            end else begin
               sec_tens_d = sec_tens_q + 3'd1;
            end
         end else begin
            sec_ones_d = sec_ones_q + 4'd1;
         end
      end else begin
         wrap_d = 1'b0;
      end
   end

   // Watchdog: cleared by tick or clear, otherwise counts up and saturates.
   always_comb begin
      timeout = (wd_q == WD_MAX) && !tick_q;
      if (clear || tick_q) begin
         wd_d = '0;
      end else if (wd_q >= WD_MAX) begin
         wd_d = WD_MAX;
      end else begin
         wd_d = wd_q + CNT_W'(1);
      end
   end

   // Lock FSM next state; a tick takes priority over a simultaneous timeout.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = WAIT_FIRST;
      end else begin
         case (state_q)
            WAIT_FIRST: begin
               if (tick_q) begin
                  state_d = RUNNING;
               end else if (timeout) begin
                  state_d = STALLED;
               end else begin
                  state_d = WAIT_FIRST;
               end
            end
            RUNNING: begin
               if (timeout) begin
                  state_d = STALLED;
               end else begin
                  state_d = RUNNING;
               end
            end
            STALLED: begin
               if (tick_q) begin
                  state_d = RUNNING;
               end else begin
                  state_d = STALLED;
               end
            end
            default: state_d = WAIT_FIRST;
         endcase
      end
      locked_d  = (state_q == RUNNING);
      stalled_d = (state_q == STALLED);
   end

   // All state registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q     <= '0;
         hist_q     <= 1'b0;
         tick_q     <= 1'b0;
         sec_ones_q <= 4'd0;
         sec_tens_q <= 3'd0;
         min_ones_q <= 4'd0;
         min_tens_q <= 3'd0;
         wrap_q     <= 1'b0;
         wd_q       <= '0;
         state_q    <= WAIT_FIRST;
         locked_q   <= 1'b0;
         stalled_q  <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         hist_q     <= hist_d;
         tick_q     <= tick_d;
         sec_ones_q <= sec_ones_d;
         sec_tens_q <= sec_tens_d;
         min_ones_q <= min_ones_d;
         min_tens_q <= min_tens_d;
         wrap_q     <= wrap_d;
         wd_q       <= wd_d;
         state_q    <= state_d;
         locked_q   <= locked_d;
         stalled_q  <= stalled_d;
      end
   end

   assign tick     = tick_q;
   assign sec_ones = sec_ones_q;
   assign sec_tens = sec_tens_q;
   assign min_ones = min_ones_q;
   assign min_tens = min_tens_q;
   assign wrap     = wrap_q;
   assign locked   = locked_q;
   assign stalled  = stalled_q;

endmodule

// File: tb/tb_slow_clk_receiver.sv
// Directed bench for slow_clk_receiver with a tick scoreboard.
module tb_slow_clk_receiver;

   logic       clk = 1'b0;
   logic       reset;
   logic       slow_in;
   logic       en;
   logic       clear;
   logic       tick;
   logic [3:0] sec_ones;
   logic [2:0] sec_tens;
   logic [3:0] min_ones;
   logic [2:0] min_tens;
   logic       wrap;
   logic       locked;
   logic       stalled;

   slow_clk_receiver #(
      .SYNC_STAGES   (2),
      .TIMEOUT_CYCLES(20),
      .CNT_W         (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .slow_in (slow_in),
      .en      (en),
      .clear   (clear),
      .tick    (tick),
      .sec_ones(sec_ones),
      .sec_tens(sec_tens),
      .min_ones(min_ones),
      .min_tens(min_tens),
      .wrap    (wrap),
      .locked  (locked),
      .stalled (stalled)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   cnt;
      logic wrp;
   } exp_t;

   exp_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   m_cnt   = 0;   // model: seconds since 00:00
   bit   pend    = 1'b0;
   bit   tprev   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One slow_in period; the model result is queued when the rise is driven.
   task automatic pulse(input int hi, input int lo, input bit lat, input bit clr);
      exp_t e;
      if (clr) begin
         m_cnt = 0;
         e.cnt = 0;
         e.wrp = 1'b0;
      end else if (en) begin
         m_cnt = (m_cnt + 1) % 3600;
         e.cnt = m_cnt;
         e.wrp = (m_cnt == 0);
      end else begin
         e.cnt = m_cnt;
         e.wrp = 1'b0;
      end
      q.push_back(e);
      slow_in = 1'b1;
      cyc(2);
      if (lat) chk("tick_before_latency", tick, 0);
      cyc(1);
      if (lat) chk("tick_at_latency", tick, 1);
      if (clr) clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      if (lat) chk("tick_one_cycle", tick, 0);
      cyc(hi - 4);
      slow_in = 1'b0;
      cyc(lo);
   endtask

   // Scoreboard: on each tick, pop the expectation and compare the next cycle.
   always @(negedge clk) begin
      if (reset) begin
         pend  = 1'b0;
         tprev = 1'b0;
      end else begin
         if (pend) begin
            exp_t e;
            e = q.pop_front();
            chk("sec_ones", sec_ones, (e.cnt % 60) % 10);
            chk("sec_tens", sec_tens, (e.cnt % 60) / 10);
            chk("min_ones", min_ones, (e.cnt / 60) % 10);
            chk("min_tens", min_tens, (e.cnt / 60) / 10);
            chk("wrap", wrap, e.wrp);
            pend = 1'b0;
         end else if (wrap) begin
            chk("wrap_idle", wrap, 0);
         end
         if (tick) begin
            chk("tick_width", tprev, 0);
            chk("tick_expected", (q.size() > 0), 1);
            pend = (q.size() > 0);
         end
         tprev = tick;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      slow_in = 1'b0;
      en      = 1'b1;
      clear   = 1'b0;
      cyc(3);
      chk("rst_tick", tick, 0);
      chk("rst_time", {sec_ones, sec_tens, min_ones, min_tens}, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_locked", locked, 0);
      chk("rst_stalled", stalled, 0);

      // Idle slow clock: stall after 20 counts plus one decode cycle.
      reset = 1'b0;
      cyc(20);
      chk("idle_stalled_early", stalled, 0);
      cyc(1);
      chk("idle_stalled", stalled, 1);
      chk("idle_locked", locked, 0);

      // 10/10 square wave: latency, recovery from STALLED, counting.
      pulse(10, 10, 1'b1, 1'b0);
      chk("run_locked", locked, 1);
      chk("run_stalled", stalled, 0);
      for (int i = 0; i < 6; i++) pulse(10, 10, 1'b1, 1'b0);   // 00:07

      // en=0 freezes the count; ticks and lock continue.
      en = 1'b0;
      for (int i = 0; i < 5; i++) pulse(10, 10, 1'b0, 1'b0);
      chk("hold_locked", locked, 1);
      chk("hold_sec_ones", sec_ones, 7);
      en = 1'b1;

      // Stop the slow clock, then resume.
      cyc(25);
      chk("stop_stalled", stalled, 1);
      chk("stop_locked", locked, 0);
      pulse(10, 10, 1'b0, 1'b0);                                  // 00:08
      chk("resume_locked", locked, 1);
      chk("resume_stalled", stalled, 0);
      for (int i = 0; i < 4; i++) pulse(10, 10, 1'b0, 1'b0);   // 00:12

      // clear together with a tick.
      pulse(10, 10, 1'b1, 1'b1);
      chk("clear_locked", locked, 0);
      chk("clear_stalled", stalled, 0);

      // Count to 59:59, then roll over.
      for (int i = 0; i < 3599; i++) pulse(4, 4, 1'b0, 1'b0);
      chk("full_min_tens", min_tens, 5);
      chk("full_min_ones", min_ones, 9);
      chk("full_sec_tens", sec_tens, 5);
      chk("full_sec_ones", sec_ones, 9);
      pulse(4, 4, 1'b0, 1'b0);
      chk("after_wrap_locked", locked, 1);

      // Async reset mid-count with a tick in flight.
      for (int i = 0; i < 3; i++) pulse(10, 10, 1'b0, 1'b0);   // 00:03
      slow_in = 1'b1;
      cyc(2);
      #2 reset = 1'b1;
      #1;
      chk("arst_tick", tick, 0);
      chk("arst_time", {sec_ones, sec_tens, min_ones, min_tens}, 0);
      chk("arst_wrap", wrap, 0);
      chk("arst_locked", locked, 0);
      chk("arst_stalled", stalled, 0);
      q.delete();
      m_cnt   = 0;
      slow_in = 1'b0;
      cyc(3);
      reset = 1'b0;
      cyc(5);
      pulse(10, 10, 1'b1, 1'b0);                                  // 00:01
      chk("post_rst_locked", locked, 1);
      cyc(2);
      chk("sb_drained", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/slow_clk_receiver.md
Name: slow_clk_receiver

Overview:
Receiving end of the ripple-divided slow clock (the 1 Hz divider output). Brings the asynchronous slow clock into the main `clk` domain and turns each rising edge into a single-cycle `tick`. Counts ticks as an MM:SS BCD time-of-day value and watches for a missing or stalled slow clock. Sits between the divider and the display/control logic. All downstream logic runs on `clk` and uses `tick` as an enable; nothing downstream is clocked by the slow clock.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on slow_in (legal 2..4)
TIMEOUT_CYCLES, 134217728, clk cycles without a tick before stall is declared (2x nominal divided period)
CNT_W, 28, width of watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  main clock; single clock domain
reset  input  1  asynchronous, active-high reset
slow_in  input  1  divided slow clock, asynchronous to clk
en  input  1  count enable for time counter
clear  input  1  synchronous clear of time counter and watchdog
tick  output  1  one-cycle pulse per slow_in rising edge
sec_ones  output  4  BCD seconds units, 0..9
sec_tens  output  3  BCD seconds tens, 0..5
min_ones  output  4  BCD minutes units, 0..9
min_tens  output  3  BCD minutes tens, 0..5
wrap  output  1  one-cycle pulse when 59:59 rolls to 00:00
locked  output  1  1 while FSM in RUNNING
stalled  output  1  1 while FSM in STALLED

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is asynchronous and active-high.
- Reset values: all sync flops and the edge-history flop 0; all counters 0; tick, wrap, locked and stalled 0; FSM in WAIT_FIRST.
- Synchronizer: slow_in passes through SYNC_STAGES flops. The edge-history flop holds the last synced value.
- Edge detection: tick = registered (synced & ~history).
  - Latency from a slow_in rise (meeting setup) to tick high: SYNC_STAGES+1 clk edges.
  - tick is high exactly 1 cycle per rising edge. Falling edges produce nothing.
- Time counter updates only on a cycle where tick=1 and en=1:
  - sec_ones increments 0..9; at 9 it wraps to 0 and carries into sec_tens.
  - sec_tens counts 0..5; it wraps to 0 and carries into min_ones.
  - min_ones counts 0..9; it carries into min_tens.
  - min_tens counts 0..5.
  - At 59:59 all fields go to 0 and wrap pulses for 1 cycle, in the same cycle as the update.
- clear has priority over tick:
  - Counter goes to 00:00 and wrap stays 0.
  - Watchdog counter goes to 0. FSM goes to WAIT_FIRST.
  - tick itself is still emitted.
- en=0 freezes the counter but does not affect tick, the watchdog or the FSM.
- Watchdog counter:
  - Cleared on tick or clear; otherwise increments and saturates at TIMEOUT_CYCLES-1.
  - Timeout event = counter equals TIMEOUT_CYCLES-1 and no tick this cycle.
- FSM states:
  - WAIT_FIRST: tick -> RUNNING; timeout -> STALLED.
  - RUNNING: timeout -> STALLED; tick stays.
  - STALLED: tick -> RUNNING (the same tick also counts if en=1).
  - clear from any state -> WAIT_FIRST.
- Outputs from FSM: locked/stalled are registered decodes of the state and update the cycle after the transition.
- Simultaneous tick and timeout in the same cycle: tick wins; the watchdog is cleared and there is no STALLED entry.
- Counter fields never hold non-BCD values. Saturated watchdog never wraps.
- Reset mid-operation: immediate return to reset values regardless of clk. A tick in flight is lost.
- slow_in glitches shorter than one clk period may be missed; the behaviour is defined only for slow_in high and low phases each ≥ SYNC_STAGES+2 clk cycles.

Test Plan:
1. Reset release, slow_in held 0, TIMEOUT_CYCLES=20 → tick never asserts; locked=0; stalled rises 21 cycles after the first post-reset edge (20 counts + 1 registered decode).
2. slow_in square wave, 10 clk high / 10 low, en=1 → tick every 20 cycles, each 1 cycle wide, first one 3 cycles (SYNC_STAGES=2) after the rise; locked=1 after the first tick; sec_ones steps 0,1,2,...
3. Preload via 3599 ticks, en=1 → fields read 59:59; the next tick gives 00:00 with wrap=1 for exactly that cycle.
4. en=0 for 5 ticks mid-count at 00:07 → value stays 00:07, tick still pulses, locked stays 1.
5. Stop slow_in for 25 cycles (TIMEOUT_CYCLES=20), then resume → stalled=1, locked=0; the first resumed tick returns to RUNNING and counts if en=1.
6. clear asserted on the same cycle as tick at 00:12 → counter 00:00, wrap=0, FSM WAIT_FIRST; async reset pulse mid-count → all outputs 0 immediately.
